pwm_stress_sequencer: RTL and testbench

- Run-controller for the multi-bit PWM stress output used to age devices under test.
- Accepts a period/high-time/period-count configuration, validates it, and runs exactly N PWM periods on a masked output bus before signalling completion.
- Applies run-time reconfiguration only on period boundaries, so no runt pulses reach the stressed devices.
- Sits between the AXI register file (cfg, start, abort, status) and the HCI output pins.

---
 rtl/pwm_seq_pkg.sv | 23 ++
 rtl/pwm_stress_sequencer_if.sv | 34 +++
 rtl/pwm_phase_gen.sv | 31 +++
 rtl/pwm_stress_sequencer.sv | 127 ++++++++++++
 tb/tb_pwm_stress_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the PWM stress sequencer.
package pwm_seq_pkg;

    localparam int unsigned CNT_W       = 32;
    localparam int unsigned NUM_SIGNALS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [CNT_W-1:0]       counter_max;
        logic [CNT_W-1:0]       counter_high_max;
        logic [NUM_SIGNALS-1:0] mask;
    } pwm_cfg_t;

    // Period must be non-empty and the high time may not exceed it.
    function automatic logic cfg_ok(pwm_cfg_t c);
        return (c.counter_max != '0) && (c.counter_high_max <= c.counter_max);
    endfunction

endpackage

// File: rtl/pwm_stress_sequencer_if.sv
// Register-file facing bundle of the PWM stress sequencer: config, controls, status and the PWM bus.
interface pwm_stress_sequencer_if #(
    parameter int unsigned num_signals = 4
);
    import pwm_seq_pkg::*;

    logic [CNT_W-1:0]       cfg_counter_max;
    logic [CNT_W-1:0]       cfg_counter_high_max;
    logic [CNT_W-1:0]       cfg_num_periods;
    logic [num_signals-1:0] cfg_signal_mask;
    logic                   cfg_update;
    logic                   start;
    logic                   abort;

    logic [num_signals-1:0] out_bus;
    logic                   busy;
    logic                   done;
    logic                   aborted;
    logic                   cfg_error;
    logic [CNT_W-1:0]       periods_done;

    modport master (
        output cfg_counter_max, cfg_counter_high_max, cfg_num_periods, cfg_signal_mask,
        output cfg_update, start, abort,
        input  out_bus, busy, done, aborted, cfg_error, periods_done
    );

    modport slave (
        input  cfg_counter_max, cfg_counter_high_max, cfg_num_periods, cfg_signal_mask,
        input  cfg_update, start, abort,
        output out_bus, busy, done, aborted, cfg_error, periods_done
    );

endinterface

// File: rtl/pwm_phase_gen.sv
// Phase counter 0..M-1 with period-end strobe and the high/low level of the upcoming cycle.
module pwm_phase_gen
    import pwm_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [CNT_W-1:0] counter_max,
    input  logic [CNT_W-1:0] counter_high_nxt,
    output logic             period_end_c,
    output logic             level_nxt_c
);

    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] phase_nxt_c;

    // Strict less-than keeps H=0 constant low without any H-1 underflow.
    assign period_end_c = enable && (phase == counter_max - CNT_W'(1));
    assign phase_nxt_c  = (restart || period_end_c) ? '0 : phase + CNT_W'(1);
    assign level_nxt_c  = phase_nxt_c < counter_high_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (restart || enable) begin
            phase <= phase_nxt_c;
        end
    end

endmodule

// File: rtl/pwm_stress_sequencer.sv
// Run controller: validates config, runs N PWM periods on the masked bus and swaps config only on period boundaries.
module pwm_stress_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned num_signals = NUM_SIGNALS
) (
    input  logic                  clk,
    input  logic                  reset,
    pwm_stress_sequencer_if.slave bus
);

    seq_state_e       state;
    pwm_cfg_t         active;
    pwm_cfg_t         pending;
    logic             pending_valid;
    logic [CNT_W-1:0] num_periods;

    pwm_cfg_t cfg_in;
    pwm_cfg_t upd_cfg;
    pwm_cfg_t cfg_nxt;
    logic     upd_valid;
    logic     start_ok_c;
    logic     apply_c;
    logic     last_period_c;
    logic     run_nxt_c;
    logic     period_end_c;
    logic     level_nxt_c;

    // An update arriving on the period-end cycle itself takes part in that boundary.
    always_comb begin
        cfg_in.counter_max      = bus.cfg_counter_max;
        cfg_in.counter_high_max = bus.cfg_counter_high_max;
        cfg_in.mask             = NUM_SIGNALS'(bus.cfg_signal_mask);
        upd_cfg                 = pending;
        upd_valid               = pending_valid;
        if (bus.cfg_update) begin
            upd_cfg   = cfg_in;
            upd_valid = 1'b1;
        end

        start_ok_c    = (state == IDLE) && bus.start && !bus.abort && cfg_ok(cfg_in)
                        && (bus.cfg_num_periods != '0);
        last_period_c = period_end_c && (bus.periods_done + CNT_W'(1) == num_periods);
        apply_c       = period_end_c && !bus.abort && upd_valid && cfg_ok(upd_cfg);
        run_nxt_c     = start_ok_c || ((state == RUN) && !bus.abort && !last_period_c);

        cfg_nxt = active;
        if (start_ok_c) begin
            cfg_nxt = cfg_in;
        end else if (apply_c) begin
            cfg_nxt = upd_cfg;
        end
    end

    pwm_phase_gen u_phase_gen (
        .clk              (clk),
        .reset            (reset),
        .enable           (state == RUN),
        .restart          (start_ok_c),
        .counter_max      (active.counter_max),
        .counter_high_nxt (cfg_nxt.counter_high_max),
        .period_end_c     (period_end_c),
        .level_nxt_c      (level_nxt_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            active           <= '0;
            pending          <= '0;
            pending_valid    <= 1'b0;
            num_periods      <= '0;
            bus.out_bus      <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.aborted      <= 1'b0;
            bus.cfg_error    <= 1'b0;
            bus.periods_done <= '0;
        end else begin
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
            bus.busy    <= run_nxt_c;
            bus.out_bus <= run_nxt_c ? (num_signals'(cfg_nxt.mask) & {num_signals{level_nxt_c}}) : '0;
            active      <= cfg_nxt;

            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (start_ok_c) begin
                            state            <= RUN;
                            num_periods      <= bus.cfg_num_periods;
                            bus.periods_done <= '0;
                            bus.cfg_error    <= 1'b0;
                            pending_valid    <= 1'b0;
                        end else begin
                            bus.cfg_error <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (period_end_c) begin
                        bus.periods_done <= bus.periods_done + CNT_W'(1);
                    end
                    if (bus.abort) begin
                        state         <= IDLE;
                        bus.aborted   <= 1'b1;
                        pending_valid <= 1'b0;
                    end else if (period_end_c) begin
                        pending_valid <= 1'b0;
                        if (upd_valid && !cfg_ok(upd_cfg)) begin
                            bus.cfg_error <= 1'b1;
                        end
                        if (last_period_c) begin
                            state    <= IDLE;
                            bus.done <= 1'b1;
                        end
                    end else if (bus.cfg_update) begin
                        pending       <= cfg_in;
                        pending_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_stress_sequencer.sv
// Bench for pwm_stress_sequencer: directed plan scenarios plus random traffic against a cycle-level reference model.
module tb_pwm_stress_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    pwm_stress_sequencer_if #(.num_signals(4)) bus ();

    pwm_stress_sequencer #(.num_signals(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: where the run is (k within the period) and what the run looks like.
    bit          m_run;
    int unsigned m_k, m_pd, m_n;
    int unsigned m_m, m_h;
    logic [3:0]  m_mask;
    bit          m_pv;
    int unsigned p_m, p_h;
    logic [3:0]  p_mask;
    bit          m_err;
    logic [3:0]  exp_out;
    bit          exp_done, exp_ab;

    function automatic bit legal(int unsigned m, int unsigned h);
        return (m >= 1) && (h <= m);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    task automatic model(bit rs, bit st, bit ab, bit up, int unsigned m, int unsigned h,
                         int unsigned n, logic [3:0] mk);
        bit pend_end;
        exp_done = 1'b0;
        exp_ab   = 1'b0;
        if (rs) begin
            m_run = 0; m_k = 0; m_pd = 0; m_err = 0; m_pv = 0;
        end else if (!m_run) begin
            if (st && !ab) begin
                if (legal(m, h) && n != 0) begin
                    m_run = 1; m_k = 0; m_pd = 0; m_err = 0; m_pv = 0;
                    m_m = m; m_h = h; m_mask = mk; m_n = n;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            pend_end = (m_k == m_m - 1);
            if (up) begin
                m_pv = 1; p_m = m; p_h = h; p_mask = mk;
            end
            if (pend_end) m_pd++;
            if (ab) begin
                m_run = 0; exp_ab = 1; m_pv = 0;
            end else if (pend_end) begin
                if (m_pv) begin
                    if (legal(p_m, p_h)) begin
                        m_m = p_m; m_h = p_h; m_mask = p_mask;
                    end else begin
                        m_err = 1;
                    end
                    m_pv = 0;
                end
                if (m_pd == m_n) begin
                    m_run = 0; exp_done = 1;
                end else begin
                    m_k = 0;
                end
            end else begin
                m_k++;
            end
        end
        exp_out = (m_run && m_k < m_h) ? m_mask : 4'h0;
    endtask

    // Compare last cycle's prediction, then drive this cycle and advance the model.
    task automatic step(bit rs, bit st, bit ab, bit up, int unsigned m, int unsigned h,
                        int unsigned n, logic [3:0] mk);
        @(negedge clk);
        cyc++;
        check("out_bus", 32'(bus.out_bus), 32'(exp_out));
        check("busy", 32'(bus.busy), 32'(m_run));
        check("done", 32'(bus.done), 32'(exp_done));
        check("aborted", 32'(bus.aborted), 32'(exp_ab));
        check("cfg_error", 32'(bus.cfg_error), 32'(m_err));
        check("periods_done", bus.periods_done, m_pd);
        reset                    = rs;
        bus.start                = st;
        bus.abort                = ab;
        bus.cfg_update           = up;
        bus.cfg_counter_max      = m;
        bus.cfg_counter_high_max = h;
        bus.cfg_num_periods      = n;
        bus.cfg_signal_mask      = mk;
        model(rs, st, ab, up, m, h, n, mk);
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    endtask

    task automatic go(int unsigned m, int unsigned h, int unsigned n, logic [3:0] mk);
        step(0, 1, 0, 0, m, h, n, mk);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.abort = 0; bus.cfg_update = 0;
        bus.cfg_counter_max = 0; bus.cfg_counter_high_max = 0;
        bus.cfg_num_periods = 0; bus.cfg_signal_mask = 0;
        model(1, 0, 0, 0, 0, 0, 0, 4'h0);

        step(1, 0, 0, 0, 0, 0, 0, 4'h0);
        idle(2);

        go(4, 1, 3, 4'hF);
        idle(13);
        check("tp1_periods", bus.periods_done, 32'd3);
        go(5, 0, 2, 4'hA); idle(12);
        go(5, 5, 2, 4'hA); idle(12);

        go(3, 4, 2, 4'hF); idle(3);
        check("bad_h_err", 32'(bus.cfg_error), 32'd1);
        go(3, 1, 0, 4'hF); idle(3);
        go(0, 0, 2, 4'hF); idle(2);
        step(0, 1, 1, 0, 2, 1, 2, 4'hF); idle(3);

        go(4, 2, 4, 4'hF);
        idle(1);
        step(0, 0, 0, 1, 2, 1, 0, 4'h3);
        idle(12);

        go(4, 2, 10, 4'hF);
        idle(6);
        step(0, 0, 1, 0, 0, 0, 0, 4'h0);
        idle(2);
        check("abort_pd", bus.periods_done, 32'd1);
        go(2, 1, 2, 4'h5);
        idle(3);
        step(0, 0, 1, 0, 0, 0, 0, 4'h0);
        idle(2);

        go(4, 2, 10, 4'hF);
        idle(5);
        step(1, 0, 0, 0, 0, 0, 0, 4'h0);
        idle(1);
        go(3, 2, 2, 4'h9);
        idle(8);

        go(4, 3, 3, 4'hF);
        idle(2);
        step(0, 0, 0, 1, 2, 3, 0, 4'h1);
        idle(13);

        go(2, 1, 1, 4'h6);
        idle(1);
        go(3, 1, 1, 4'h7);
        idle(5);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 4),
                 4'($urandom));
        end
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
